// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC rotation core: angle encoding, gain,
// FSM state encoding and the arctangent table.
package cordic_pkg;

  // Angle tables are stored at this native width (2^32 units per turn)
  localparam int ANGLE_W = 32;

  // Width of the micro-rotation index (supports up to 32 iterations)
  localparam int IDX_W = 5;

  // +90 degrees in binary-angle units
  localparam logic [ANGLE_W-1:0] ANGLE_90 = 32'h4000_0000;

  // CORDIC gain K = 1.6467603 encoded as Q2.30
  localparam logic [31:0] CORDIC_GAIN = 32'd1768195408;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ATAN[i] = round(atan(2^-i) * 2^32 / (2*pi))
  localparam logic [ANGLE_W-1:0] ATAN_TABLE [0:31] = '{
    32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, rescaled from the 32-bit native table
// to the datapath angle width.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [WIDTH-1:0] o_atan
);

  logic [ANGLE_W-1:0] w_entry;

  assign w_entry = ATAN_TABLE[i_idx];

  // Binary angles scale by keeping the most significant bits
  generate
    if (WIDTH == ANGLE_W) begin : g_native
      assign o_atan = w_entry;
    end else if (WIDTH > ANGLE_W) begin : g_wider
      assign o_atan = {w_entry, {(WIDTH-ANGLE_W){1'b0}}};
    end else begin : g_narrower
      assign o_atan = w_entry[ANGLE_W-1 -: WIDTH];
    end
  endgenerate

endmodule

// File: rtl/cordic_rotation_core.sv
// Iterative CORDIC rotation engine: one shift-add micro-rotation per clock,
// valid/ready on both sides, output scaled by the CORDIC gain K.
module cordic_rotation_core
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] angle_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out
);

  localparam int              XW   = WIDTH + 2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITER - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_iter;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [WIDTH-1:0] r_z;
  logic signed [XW-1:0]    r_x_out;
  logic signed [XW-1:0]    r_y_out;
  logic                    r_out_valid;
  logic                    r_in_ready;

  logic [WIDTH-1:0]        w_atan;
  logic signed [XW-1:0]    w_x_sh;
  logic signed [XW-1:0]    w_y_sh;
  logic                    w_d_pos;
  logic signed [XW-1:0]    w_x_next;
  logic signed [XW-1:0]    w_y_next;
  logic signed [WIDTH-1:0] w_z_next;

  cordic_atan_rom #(.WIDTH(WIDTH)) u_atan_rom (
    .i_idx  (r_iter),
    .o_atan (w_atan)
  );

  // One micro-rotation, all terms taken from the pre-update registers;
  // z == 0 rotates in the positive direction
  assign w_x_sh   = r_x >>> r_iter;
  assign w_y_sh   = r_y >>> r_iter;
  assign w_d_pos  = ~r_z[WIDTH-1];
  assign w_x_next = w_d_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
  assign w_y_next = w_d_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
  assign w_z_next = w_d_pos ? (r_z - $signed(w_atan)) : (r_z + $signed(w_atan));

  // Control FSM, iteration datapath and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here uses <= so all updates see the pre-edge
    // values; blocking assignments would chain x, y and z within one cycle.
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_iter      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x        <= {{2{x_in[WIDTH-1]}}, x_in};
            r_y        <= {{2{y_in[WIDTH-1]}}, y_in};
            r_z        <= angle_in;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_x    <= w_x_next;
          r_y    <= w_y_next;
          r_z    <= w_z_next;
          r_iter <= r_iter + IDX_W'(1);
          if (r_iter == LAST) begin
            r_x_out     <= w_x_next;
            r_y_out     <= w_y_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // New input is only taken once back in IDLE, never in this cycle
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign x_out     = r_x_out;
  assign y_out     = r_y_out;

endmodule

// File: tb/tb_cordic_rotation_core.sv
// Directed-vector bench for cordic_rotation_core: reset values, latency,
// rotations at 0/45/-90/60 degrees, back-pressure and mid-run reset.
module tb_cordic_rotation_core;

  localparam int WIDTH = 32;
  localparam int ITER  = 16;

  // K16 * 2^28 and K16 * 2^28 * cos(45deg), K16 = 1.64676026
  localparam longint K28     = 442048842;
  localparam longint K28_45  = 312575733;
  localparam longint TOL     = 53961;     // 2^-13 of K*2^28

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] angle_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH+1:0] x_out;
  logic signed [WIDTH+1:0] y_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_rotation_core #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol);
    n_vec++;
    if (got > exp + tol || got < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, got, exp, tol);
    end
  endtask

  // Present one vector at a negedge and hold it across the accepting edge
  task automatic send(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                      input logic signed [WIDTH-1:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1, 0);
    in_valid = 1'b1;
    x_in     = x;
    y_in     = y;
    angle_in = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = $urandom;
    y_in     = $urandom;
    angle_in = $urandom;
  endtask

  // Count edges from the accept edge until out_valid is seen
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic signed [WIDTH-1:0] x,
                           input logic signed [WIDTH-1:0] y, input logic signed [WIDTH-1:0] a,
                           input longint ex, input longint ey, input longint tol);
    int n;
    send(x, y, a);
    wait_out(n);
    check({tag, "_latency"}, n, ITER, 0);
    check({tag, "_x"}, x_out, ex, tol);
    check({tag, "_y"}, y_out, ey, tol);
    consume();
    check({tag, "_valid_drop"}, out_valid, 0, 0);
    check({tag, "_ready_back"}, in_ready, 1, 0);
  endtask

  initial begin
    logic signed [WIDTH+1:0] hx;
    logic signed [WIDTH+1:0] hy;
    logic                    ok;
    int                      n;

    // Reset with random inputs toggling
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_in      = '0;
    y_in      = '0;
    angle_in  = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      x_in      = $urandom;
      y_in      = $urandom;
      angle_in  = $urandom;
    end
    check("rst_in_ready", in_ready, 1, 0);
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_x_out", x_out, 0, 0);
    check("rst_y_out", y_out, 0, 0);

    // Release and idle: reset values must hold
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== '0 || y_out !== '0) ok = 1'b0;
    end
    check("post_rst_idle", ok, 1, 0);

    // Directed rotations
    run_check("deg0",   32'sd268435456, 32'sd0,  32'sh0000_0000, K28,    0,      TOL);
    run_check("deg45",  32'sd268435456, 32'sd0,  32'sh2000_0000, K28_45, K28_45, TOL);
    run_check("degm90", 32'sd268435456, 32'sd0,  32'shC000_0000, 0,      -K28,   TOL);
    // K*(20cos60 - 40sin60) = -40.58, K*(20sin60 + 40cos60) = 61.46
    run_check("deg60",  32'sd20,        32'sd40, 32'sh2AAA_AAAA, -41,    61,     4);

    // Back-pressure: hold out_ready low, pulse a stray in_valid
    send(32'sd268435456, 32'sd0, 32'sh2000_0000);
    wait_out(n);
    check("bp_latency", n, ITER, 0);
    hx = x_out;
    hy = y_out;
    check("bp_x", hx, K28_45, TOL);
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        in_valid = 1'b1;
        x_in     = 32'sd1000;
        y_in     = 32'sd2000;
        angle_in = 32'sh1000_0000;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== hx || y_out !== hy) ok = 1'b0;
    end
    in_valid = 1'b0;
    check("bp_stable", ok, 1, 0);
    consume();
    check("bp_ready_next", in_ready, 1, 0);
    check("bp_valid_drop", out_valid, 0, 0);
    run_check("after_bp", 32'sd268435456, 32'sd0, 32'sh0000_0000, K28, 0, TOL);

    // Reset in the middle of a run (counter at 5)
    send(32'sd268435456, 32'sd0, 32'sh0000_0000);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1, 0);
    check("midrst_out_valid", out_valid, 0, 0);
    check("midrst_x_out", x_out, 0, 0);
    check("midrst_y_out", y_out, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
    end
    check("midrst_no_output", ok, 1, 0);
    run_check("post_midrst", 32'sd268435456, 32'sd0, 32'sh0000_0000, K28, 0, TOL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
